// File: rtl/accu_reader.sv
// accu_reader: consumer side of the windowed accumulator interface.
// Captures signed window sums into a small FIFO. Each entry is tagged with a
// threshold flag at write time. Entries are presented downstream on
// valid/ready. Dropped writes raise a sticky overflow flag.
module accu_reader #(
    parameter int DATA_WIDTH = 37,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] thresh,
    input  logic                  out_ready,
    input  logic                  clr_ovf,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_flag,
    output logic                  out_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  overflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    // Stored entry: {flag, data}.
    typedef logic [DATA_WIDTH:0] entry_t;

    entry_t                mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;

    logic   push, pop, drop;
    logic   flag_new;
    entry_t head;

    assign full      = (count_q == CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign pop       = out_ready && out_valid;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push      = in_valid && (!full || pop);
    assign drop      = in_valid && full && !pop;
    assign flag_new  = ($signed(in_data) > $signed(thresh));

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A drop takes priority over a clear in the same cycle.
        if (drop)         overflow_d = 1'b1;
        else if (clr_ovf) overflow_d = 1'b0;
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage. The threshold flag is computed here, at write time.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the array is reset so the head reads 0 out of reset; this
        // forces flops rather than a RAM macro, acceptable at this depth.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= {flag_new, in_data};
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign out_data = head[DATA_WIDTH-1:0];
    assign out_flag = head[DATA_WIDTH];
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_accu_reader.sv
// Directed bench for accu_reader: a vector table plus hand-written
// sequences for reset, idle and the asynchronous mid-operation reset.
module tb_accu_reader;

    localparam int DW = 37;
    localparam int AW = 2;
    localparam longint MOST_NEG = -(longint'(1) <<< 36);

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic [DW-1:0] thresh;
    logic          out_ready;
    logic          clr_ovf;
    logic [DW-1:0] out_data;
    logic          out_flag;
    logic          out_valid;
    logic [AW:0]   count;
    logic          full;
    logic          overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    accu_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .thresh    (thresh),
        .out_ready (out_ready),
        .clr_ovf   (clr_ovf),
        .out_data  (out_data),
        .out_flag  (out_flag),
        .out_valid (out_valid),
        .count     (count),
        .full      (full),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic   v;
        longint d;
        longint t;
        logic   rdy;
        logic   clr;
        int     e_cnt;
        logic   e_val;
        longint e_data;
        logic   e_flag;
        logic   e_full;
        logic   e_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, longint d, longint t, logic rdy, logic clr,
                                int e_cnt, logic e_val, longint e_data, logic e_flag,
                                logic e_full, logic e_ovf);
        vec_t r;
        r.v = v; r.d = d; r.t = t; r.rdy = rdy; r.clr = clr;
        r.e_cnt = e_cnt; r.e_val = e_val; r.e_data = e_data; r.e_flag = e_flag;
        r.e_full = e_full; r.e_ovf = e_ovf;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".count"},    64'(count),     64'd0);
        check({tag, ".valid"},    64'(out_valid), 64'd0);
        check({tag, ".full"},     64'(full),      64'd0);
        check({tag, ".overflow"}, 64'(overflow),  64'd0);
    endtask

    task automatic drive(input logic v, input longint d, input longint t,
                         input logic rdy, input logic clr);
        in_valid  = v;
        in_data   = DW'(d);
        thresh    = DW'(t);
        out_ready = rdy;
        clr_ovf   = clr;
    endtask

    initial begin
        logic [DW-1:0] exp_d;

        // Vector table: inputs held across one edge; outputs checked 1 ns after.
        // Single transfer, thresh = 100
        vecs.push_back(mk(1, 250, 100, 1, 0, 1, 1, 250, 1, 0, 0));
        vecs.push_back(mk(1,  -5, 100, 1, 0, 1, 1,  -5, 0, 0, 0));
        vecs.push_back(mk(0,   0, 100, 1, 0, 0, 0,   0, 0, 0, 0));
        // Ordering under back-pressure
        vecs.push_back(mk(1,  10, 100, 0, 0, 1, 1,  10, 0, 0, 0));
        vecs.push_back(mk(1,  20, 100, 0, 0, 2, 1,  10, 0, 0, 0));
        vecs.push_back(mk(1,  30, 100, 0, 0, 3, 1,  10, 0, 0, 0));
        vecs.push_back(mk(1,  40, 100, 0, 0, 4, 1,  10, 0, 1, 0));
        // Overflow: drop, clear, drop+clear (set wins), clear
        vecs.push_back(mk(1,  50, 100, 0, 0, 4, 1,  10, 0, 1, 1));
        vecs.push_back(mk(0,   0, 100, 0, 1, 4, 1,  10, 0, 1, 0));
        vecs.push_back(mk(1,  60, 100, 0, 1, 4, 1,  10, 0, 1, 1));
        vecs.push_back(mk(0,   0, 100, 0, 1, 4, 1,  10, 0, 1, 0));
        // Drain in order
        vecs.push_back(mk(0,   0, 100, 1, 0, 3, 1,  20, 0, 0, 0));
        vecs.push_back(mk(0,   0, 100, 1, 0, 2, 1,  30, 0, 0, 0));
        vecs.push_back(mk(0,   0, 100, 1, 0, 1, 1,  40, 0, 0, 0));
        vecs.push_back(mk(0,   0, 100, 1, 0, 0, 0,   0, 0, 0, 0));
        // Full with simultaneous pop
        vecs.push_back(mk(1,   1, 100, 0, 0, 1, 1,   1, 0, 0, 0));
        vecs.push_back(mk(1,   2, 100, 0, 0, 2, 1,   1, 0, 0, 0));
        vecs.push_back(mk(1,   3, 100, 0, 0, 3, 1,   1, 0, 0, 0));
        vecs.push_back(mk(1,   4, 100, 0, 0, 4, 1,   1, 0, 1, 0));
        vecs.push_back(mk(1,   5, 100, 1, 0, 4, 1,   2, 0, 1, 0));
        vecs.push_back(mk(0,   0, 100, 1, 0, 3, 1,   3, 0, 0, 0));
        vecs.push_back(mk(0,   0, 100, 1, 0, 2, 1,   4, 0, 0, 0));
        vecs.push_back(mk(0,   0, 100, 1, 0, 1, 1,   5, 0, 0, 0));
        vecs.push_back(mk(0,   0, 100, 1, 0, 0, 0,   0, 0, 0, 0));
        // Threshold boundaries: equal is not greater; 0 > most-negative
        vecs.push_back(mk(1, 100, 100, 0, 0, 1, 1, 100, 0, 0, 0));
        vecs.push_back(mk(0,   0, 100, 1, 0, 0, 0,   0, 0, 0, 0));
        vecs.push_back(mk(1,   0, MOST_NEG, 0, 0, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0,   0, MOST_NEG, 1, 0, 0, 0, 0, 0, 0, 0));
        // Flag captured at write time survives a later threshold change
        vecs.push_back(mk(1, 500, 1000, 0, 0, 1, 1, 500, 0, 0, 0));
        vecs.push_back(mk(0,   0,    0, 0, 0, 1, 1, 500, 0, 0, 0));
        vecs.push_back(mk(1,  -1,   -2, 0, 0, 2, 1, 500, 0, 0, 0));
        vecs.push_back(mk(0,   0,    0, 1, 0, 1, 1,  -1, 1, 0, 0));
        vecs.push_back(mk(0,   0,    0, 1, 0, 0, 0,   0, 0, 0, 0));

        // Reset, asserted asynchronously mid-cycle
        drive(0, 0, 100, 0, 0);
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_idle("rst0");
        check("rst0.data", 64'(out_data), 64'd0);
        check("rst0.flag", 64'(out_flag), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Idle: nothing changes for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_idle($sformatf("idle%0d", i));
        end

        // Table-driven vectors
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].d, vecs[i].t, vecs[i].rdy, vecs[i].clr);
            @(posedge clk); #1;
            check($sformatf("v%0d.count", i),    64'(count),     64'(vecs[i].e_cnt));
            check($sformatf("v%0d.valid", i),    64'(out_valid), 64'(vecs[i].e_val));
            check($sformatf("v%0d.full", i),     64'(full),      64'(vecs[i].e_full));
            check($sformatf("v%0d.overflow", i), 64'(overflow),  64'(vecs[i].e_ovf));
            if (vecs[i].e_val) begin
                exp_d = DW'(vecs[i].e_data);
                check($sformatf("v%0d.data", i), 64'(out_data), 64'(exp_d));
                check($sformatf("v%0d.flag", i), 64'(out_flag), 64'(vecs[i].e_flag));
            end
        end

        // Mid-operation reset: 3 entries stored plus a sticky overflow
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1, 70 + i, 100, 0, 0);
        end
        @(negedge clk);
        drive(1, 99, 100, 0, 0);
        @(posedge clk); #1;
        check("pre_rst.count",    64'(count),    64'd4);
        check("pre_rst.overflow", 64'(overflow), 64'd1);
        drive(0, 0, 100, 0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        drive(0, 0, 100, 1, 0);
        @(posedge clk); #2;
        check("pre_rst3.count", 64'(count), 64'd3);
        rst = 1'b1;
        #1;
        check_idle("midrst");
        @(negedge clk);
        rst = 1'b0;
        drive(1, 7, 100, 0, 0);
        @(posedge clk); #1;
        check("post_rst.count", 64'(count),     64'd1);
        check("post_rst.valid", 64'(out_valid), 64'd1);
        check("post_rst.data",  64'(out_data),  64'd7);
        check("post_rst.flag",  64'(out_flag),  64'd0);
        @(negedge clk);
        drive(0, 0, 100, 1, 0);
        @(posedge clk); #1;
        check_idle("post_rst_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/accu_reader.md
# accu_reader

Consumer side of the windowed accumulator interface. It captures each 37-bit signed window sum presented with a one-cycle valid pulse and buffers it in a small FIFO. It presents buffered sums downstream on a valid/ready handshake and flags each sum against a programmable signed threshold. It sits between the accumulator stage and the downstream FIFO/feature logic. It absorbs back-pressure so that no window result is silently lost.

## Interface
- `DATA_WIDTH`, 37: width of the signed window sum.
- `ADDR_WIDTH`, 2: FIFO address width. Depth is `2**ADDR_WIDTH`, default 4 entries.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: reset. Asynchronous, active-high.
- `in_data` in `DATA_WIDTH`: signed window sum from the accumulator.
- `in_valid` in 1: one-cycle pulse. `in_data` is good this cycle.
- `thresh` in `DATA_WIDTH`: signed threshold. Quasi-static; sampled with every write.
- `out_ready` in 1: downstream accepts the head entry this cycle.
- `clr_ovf` in 1: synchronous clear of the `overflow` flag.
- `out_data` out `DATA_WIDTH`: signed head-of-FIFO sum.
- `out_flag` out 1: head entry `out_data > thresh` (signed compare, strict), captured at write time.
- `out_valid` out 1: FIFO non-empty.
- `count` out `ADDR_WIDTH+1`: number of stored entries, 0..DEPTH.
- `full` out 1: `count == DEPTH`.
- `overflow` out 1: sticky. Set when a pulse is dropped.

## Operation
- Storage is a DEPTH-entry array of `{flag, data}`, `DATA_WIDTH+1` bits.
- Write pointer `wr_ptr` and read pointer `rd_ptr` are `ADDR_WIDTH` bits each and wrap modulo DEPTH.
- push = `in_valid && (!full || pop)`.
- pop = `out_ready && out_valid`.
- On push, the entry `{($signed(in_data) > $signed(thresh)), in_data}` is written at `wr_ptr`, then `wr_ptr` increments.
- On pop, `rd_ptr` increments.
- `count` update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
- Full with simultaneous pop: the push is accepted. The entry freed by the pop is reused, `count` stays DEPTH, and `overflow` is not set.
- Full without pop: `in_valid` is dropped, contents are unchanged, and `overflow` is set on the next edge.
- Empty: `out_ready` is ignored and pop is 0. A push while empty is not bypassed; the entry appears on the following cycle.
- `overflow`:
  - Set by a drop.
  - Cleared by `clr_ovf`.
  - If a drop and `clr_ovf` occur in the same cycle, set wins.
- `out_data`/`out_flag` are a combinational read of the entry at `rd_ptr`. They hold stable while `out_valid && !out_ready`.
- `thresh` is applied per entry at write time. Changing it never alters stored flags.
- Signed arithmetic only. No width change; `in_data` is stored bit-exact.

## Timing
- Reset values: `wr_ptr=0`, `rd_ptr=0`, `count=0`, `out_valid=0`, `full=0`, `overflow=0`. `out_data`/`out_flag` are 0; the array is cleared on reset.
- Write latency: `in_valid` sampled at edge N gives `out_valid=1` and the new head data after edge N, one cycle.
- Handshake: an entry transfers at any edge where `out_valid && out_ready`. The next entry, if any, is presented in the following cycle.
- Sustained throughput is one push and one pop per cycle.
- Reset mid-operation: `rst` asserted at any time immediately empties the FIFO, drops all entries, and clears `overflow`, independent of `clk`. The first push after deassertion follows the normal 1-cycle latency.
- `in_valid` is not required to be a single-cycle pulse. Every cycle it is high counts as one push attempt.

## Test plan
- Reset/idle: assert `rst` asynchronously mid-cycle. Required: `count=0`, `out_valid=0`, `overflow=0` before the next edge. Then, with `in_valid` held low for 10 cycles, outputs stay unchanged.
- Single transfer with `thresh=100` and `out_ready=1`:
  - Pulse `in_data=250`. Required: one cycle later `out_valid=1`, `out_data=250`, `out_flag=1`, `count=1`.
  - Pulse `in_data=-5`. Required: `out_flag=0`.
- Ordering under back-pressure: `out_ready=0`, push 10, 20, 30, 40.
  - Required: `count=4`, `full=1`, head=10.
  - Then `out_ready=1`. Required: outputs 10, 20, 30, 40 on consecutive cycles, then `out_valid=0`.
- Overflow: FIFO full, `out_ready=0`, push 50.
  - Required: 50 is discarded, `count=4`, `overflow=1`.
  - Pulse `clr_ovf`. Required: `overflow=0`.
  - Drop and `clr_ovf` in the same cycle. Required: `overflow=1`.
- Full with simultaneous pop: FIFO holds 1,2,3,4; same cycle `out_ready=1` and push 5.
  - Required: `count=4`, `overflow=0`, drained sequence 2,3,4,5.
- Reset mid-operation and threshold boundary:
  - With 3 entries stored, assert `rst`. Required: empty, and after release a push of 7 emerges alone.
  - `in_data == thresh`. Required: `out_flag=0`.
  - `thresh` = most-negative value and `in_data=0`. Required: `out_flag=1`.
